// File: rtl/responder_pkg.sv
// rtl/responder_pkg.sv - shared state encoding and winner-select helpers for the quiz responder
package responder_pkg;

    localparam int MAX_CH   = 32;
    localparam int MAX_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        LOCK    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Lowest set bit wins: scan from the top so the last hit is the lowest index.
    function automatic logic [MAX_CH-1:0] prio_onehot(input logic [MAX_CH-1:0] vec);
        logic [MAX_CH-1:0] r_res;
        r_res = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r_res    = '0;
                r_res[i] = 1'b1;
            end
        end
        return r_res;
    endfunction

    function automatic logic [MAX_ID_W-1:0] onehot2bin(input logic [MAX_CH-1:0] oh);
        logic [MAX_ID_W-1:0] r_bin;
        r_bin = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                r_bin = r_bin | MAX_ID_W'(i);
            end
        end
        return r_bin;
    endfunction

endpackage

// File: rtl/responder_countdown.sv
// rtl/responder_countdown.sv - answer-time countdown with reload, hold and final-tick strobe
module responder_countdown #(
    parameter int T_ANSWER = 30,
    parameter int CNT_W    = $clog2(T_ANSWER + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_tick,
    input  logic             i_hold,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_value;
    logic             w_dec;

    assign w_dec   = i_tick & ~i_hold & (r_value != '0);
    // o_zero flags the tick that takes the count from 1 to 0 this cycle.
    assign o_zero  = w_dec & (r_value == CNT_W'(1));
    assign o_value = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= CNT_W'(T_ANSWER);
        end else if (w_dec) begin
            r_value <= r_value - CNT_W'(1);
        end
    end

endmodule

// File: rtl/quiz_responder_ctrl.sv
// rtl/quiz_responder_ctrl.sv - N-channel quiz responder: arm, first-press lockout, countdown, fouls
module quiz_responder_ctrl
    import responder_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int T_ANSWER = 30,
    parameter  int FOUL_EN  = 1,
    localparam int CNT_W    = $clog2(T_ANSWER + 1),
    localparam int ID_W     = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [N_CH-1:0]  i_btn,
    output logic             o_en_count,
    output logic             o_lock_flag,
    output logic             o_timeout,
    output logic [N_CH-1:0]  o_winner_oh,
    output logic [ID_W-1:0]  o_winner_id,
    output logic [CNT_W-1:0] o_time_left,
    output logic [N_CH-1:0]  o_foul
);

    state_t              r_state;
    state_t              w_state_next;
    logic [N_CH-1:0]     r_btn_q;
    logic [N_CH-1:0]     r_foul;
    logic [N_CH-1:0]     r_winner_oh;
    logic [ID_W-1:0]     r_winner_id;
    logic                r_en_count;
    logic                r_lock_flag;
    logic                r_timeout;

    logic [N_CH-1:0]     w_press;
    logic [N_CH-1:0]     w_foul_mask;
    logic [N_CH-1:0]     w_elig;
    logic                w_any_elig;
    logic [MAX_CH-1:0]   w_elig_ext;
    logic [MAX_CH-1:0]   w_oh_ext;
    logic [MAX_ID_W-1:0] w_bin_ext;
    logic [N_CH-1:0]     w_win_oh;
    logic [ID_W-1:0]     w_win_id;
    logic                w_load;
    logic                w_hold;
    logic                w_zero;
    logic                w_unused;

    assign w_press     = i_btn & ~r_btn_q;
    assign w_foul_mask = (FOUL_EN != 0) ? r_foul : '0;
    assign w_elig      = w_press & ~w_foul_mask;
    assign w_any_elig  = |w_elig;

    always_comb begin
        w_elig_ext           = '0;
        w_elig_ext[N_CH-1:0] = w_elig;
    end

    assign w_oh_ext = prio_onehot(w_elig_ext);
    assign w_bin_ext = onehot2bin(w_oh_ext);
    assign w_win_oh = w_oh_ext[N_CH-1:0];
    assign w_win_id = w_bin_ext[ID_W-1:0];
    assign w_unused = ^{w_oh_ext, w_bin_ext};

    // The counter only moves in COUNT, and freezes on the cycle a winner latches.
    assign w_load = (r_state == IDLE) & i_start & ~i_clear;
    assign w_hold = (r_state != COUNT) | w_any_elig;

    responder_countdown #(
        .T_ANSWER (T_ANSWER),
        .CNT_W    (CNT_W)
    ) u_countdown (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (i_clear),
        .i_load  (w_load),
        .i_tick  (i_tick),
        .i_hold  (w_hold),
        .o_value (o_time_left),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_start) w_state_next = COUNT;
                COUNT: begin
                    if (w_any_elig) begin
                        w_state_next = LOCK;
                    end else if (w_zero) begin
                        w_state_next = TIMEOUT;
                    end
                end
                LOCK:    w_state_next = LOCK;
                TIMEOUT: w_state_next = TIMEOUT;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_btn_q     <= '0;
            r_en_count  <= 1'b0;
            r_lock_flag <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_btn_q     <= i_btn;
            r_en_count  <= (w_state_next == COUNT);
            r_lock_flag <= (w_state_next == LOCK);
            r_timeout   <= (w_state_next == TIMEOUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_foul      <= '0;
            r_winner_oh <= '0;
            r_winner_id <= '0;
        end else if (i_clear) begin
            r_foul      <= '0;
            r_winner_oh <= '0;
            r_winner_id <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_foul <= r_foul | w_press;
            end
            if ((r_state == COUNT) && w_any_elig) begin
                r_winner_oh <= w_win_oh;
                r_winner_id <= w_win_id;
            end
        end
    end

    assign o_en_count  = r_en_count;
    assign o_lock_flag = r_lock_flag;
    assign o_timeout   = r_timeout;
    assign o_winner_oh = r_winner_oh;
    assign o_winner_id = r_winner_id;
    assign o_foul      = r_foul;

endmodule

// File: tb/tb_quiz_responder_ctrl.sv
// tb/tb_quiz_responder_ctrl.sv - scoreboard bench for quiz_responder_ctrl (N_CH=4, T_ANSWER=30, FOUL_EN=1)
module tb_quiz_responder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_clear;
    logic       i_tick;
    logic [3:0] i_btn;
    logic       o_en_count;
    logic       o_lock_flag;
    logic       o_timeout;
    logic [3:0] o_winner_oh;
    logic [1:0] o_winner_id;
    logic [4:0] o_time_left;
    logic [3:0] o_foul;

    typedef struct {
        logic       en;
        logic       lk;
        logic       to;
        logic [3:0] woh;
        logic [1:0] wid;
        logic [4:0] tl;
        logic [3:0] foul;
    } exp_t;

    exp_t q_exp[$];

    int         n_chk = 0;
    int         n_err = 0;

    int         m_state;
    int         m_tl;
    logic [3:0] m_foul;
    logic [3:0] m_woh;
    int         m_wid;
    logic [3:0] m_btnq;

    quiz_responder_ctrl #(
        .N_CH     (4),
        .T_ANSWER (30),
        .FOUL_EN  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_clear     (i_clear),
        .i_tick      (i_tick),
        .i_btn       (i_btn),
        .o_en_count  (o_en_count),
        .o_lock_flag (o_lock_flag),
        .o_timeout   (o_timeout),
        .o_winner_oh (o_winner_oh),
        .o_winner_id (o_winner_id),
        .o_time_left (o_time_left),
        .o_foul      (o_foul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_tl    = 0;
        m_foul  = 4'b0;
        m_woh   = 4'b0;
        m_wid   = 0;
        m_btnq  = 4'b0;
    endtask

    task automatic push_model();
        exp_t e;
        e.en   = (m_state == 1);
        e.lk   = (m_state == 2);
        e.to   = (m_state == 3);
        e.woh  = m_woh;
        e.wid  = 2'(m_wid);
        e.tl   = 5'(m_tl);
        e.foul = m_foul;
        q_exp.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (q_exp.size() == 0) begin
            chk("queue_underflow", 32'(q_exp.size()), 32'd1);
        end else begin
            e = q_exp.pop_front();
            chk("en_count",  32'(o_en_count),  32'(e.en));
            chk("lock_flag", 32'(o_lock_flag), 32'(e.lk));
            chk("timeout",   32'(o_timeout),   32'(e.to));
            chk("winner_oh", 32'(o_winner_oh), 32'(e.woh));
            chk("winner_id", 32'(o_winner_id), 32'(e.wid));
            chk("time_left", 32'(o_time_left), 32'(e.tl));
            chk("foul",      32'(o_foul),      32'(e.foul));
        end
    endtask

    task automatic step(input logic s, input logic c, input logic t, input logic [3:0] b);
        logic [3:0] press;
        logic [3:0] elig;
        @(negedge clk);
        i_start = s;
        i_clear = c;
        i_tick  = t;
        i_btn   = b;
        press = b & ~m_btnq;
        if (c) begin
            m_state = 0;
            m_tl    = 0;
            m_foul  = 4'b0;
            m_woh   = 4'b0;
            m_wid   = 0;
        end else begin
            case (m_state)
                0: begin
                    m_foul = m_foul | press;
                    if (s) begin
                        m_state = 1;
                        m_tl    = 30;
                    end
                end
                1: begin
                    elig = press & ~m_foul;
                    if (elig != 4'b0) begin
                        for (int i = 3; i >= 0; i--) begin
                            if (elig[i]) m_wid = i;
                        end
                        m_woh   = 4'b0001 << m_wid;
                        m_state = 2;
                    end else if (t) begin
                        if (m_tl > 1) begin
                            m_tl = m_tl - 1;
                        end else begin
                            m_tl    = 0;
                            m_state = 3;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_btnq = b;
        push_model();
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_clear = 1'b0;
        i_tick  = 1'b0;
        i_btn   = 4'b0;
        model_reset();
        push_model();
        @(posedge clk);
        #1;
        pop_compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_clear = 1'b0;
        i_tick  = 1'b0;
        i_btn   = 4'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_count",  32'(o_en_count),  32'd0);
        chk("rst_lock_flag", 32'(o_lock_flag), 32'd0);
        chk("rst_time_left", 32'(o_time_left), 32'd0);
        chk("rst_foul",      32'(o_foul),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of a countdown
        step(1, 0, 0, 4'b0000);
        repeat (13) step(0, 0, 1, 4'b0000);
        chk("mid_count_tl", 32'(o_time_left), 32'd17);
        do_reset();
        chk("post_rst_en", 32'(o_en_count), 32'd0);

        // basic win with frozen count
        step(1, 0, 0, 4'b0000);
        repeat (3) step(0, 0, 1, 4'b0000);
        step(0, 0, 1, 4'b0100);
        chk("t2_lock", 32'(o_lock_flag), 32'd1);
        chk("t2_woh",  32'(o_winner_oh), 32'h4);
        chk("t2_wid",  32'(o_winner_id), 32'd2);
        chk("t2_tl",   32'(o_time_left), 32'd27);
        step(0, 0, 1, 4'b0000);
        step(0, 0, 1, 4'b0001);
        chk("t2_wid_hold", 32'(o_winner_id), 32'd2);
        chk("t2_tl_hold",  32'(o_time_left), 32'd27);
        step(0, 1, 0, 4'b0000);

        // simultaneous presses resolve to lowest index
        step(1, 0, 0, 4'b0000);
        step(0, 0, 1, 4'b0000);
        step(0, 0, 0, 4'b1010);
        chk("t3_wid", 32'(o_winner_id), 32'd1);
        step(0, 1, 0, 4'b0000);

        // foul blocks the fouled channel only
        step(0, 0, 0, 4'b1000);
        chk("t4_foul", 32'(o_foul), 32'h8);
        step(0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'b0000);
        step(0, 0, 0, 4'b1000);
        chk("t4_nolock", 32'(o_lock_flag), 32'd0);
        step(0, 0, 0, 4'b0000);
        step(0, 0, 0, 4'b0001);
        chk("t4_wid", 32'(o_winner_id), 32'd0);
        step(0, 1, 0, 4'b0000);
        chk("t4_foul_clr", 32'(o_foul), 32'd0);

        // unanswered round times out, then a last-tick press beats the timeout
        step(1, 0, 0, 4'b0000);
        repeat (29) step(0, 0, 1, 4'b0000);
        chk("t5_tl1", 32'(o_time_left), 32'd1);
        step(0, 0, 1, 4'b0000);
        chk("t5_timeout", 32'(o_timeout),   32'd1);
        chk("t5_tl0",     32'(o_time_left), 32'd0);
        chk("t5_en",      32'(o_en_count),  32'd0);
        step(1, 0, 1, 4'b0001);
        chk("t5_to_hold", 32'(o_timeout), 32'd1);
        step(0, 1, 0, 4'b0000);
        step(1, 0, 0, 4'b0000);
        repeat (29) step(0, 0, 1, 4'b0000);
        step(0, 0, 1, 4'b0010);
        chk("t5_lock", 32'(o_lock_flag), 32'd1);
        chk("t5_tl_1", 32'(o_time_left), 32'd1);
        step(0, 1, 0, 4'b0000);

        // held button across start must be re-pressed
        step(0, 1, 0, 4'b0010);
        step(1, 0, 0, 4'b0010);
        step(0, 0, 1, 4'b0010);
        chk("t6_nolock", 32'(o_lock_flag), 32'd0);
        step(0, 0, 0, 4'b0000);
        step(0, 0, 0, 4'b0010);
        chk("t6_wid", 32'(o_winner_id), 32'd1);
        chk("t6_lock", 32'(o_lock_flag), 32'd1);
        step(0, 1, 0, 4'b0000);
        step(1, 1, 0, 4'b0000);
        chk("t6_start_clear", 32'(o_en_count), 32'd0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [3:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 1) == 1), rb);
        end

        chk("queue_empty", 32'(q_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
